riscv_core_div_iter: RTL and testbench

RISCV_CORE_DIV_ITER -- requirements
Module: riscv_core_div_iter

---
 rtl/riscv_core_div_iter.sv | 217 +++++++++++++++++++++
 tb/tb_riscv_core_div_iter.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_core_div_iter.sv
// -----------------------------------------------------------------------------
// riscv_core_div_iter
//
// Iterative restoring divider for the RV32M/RV64M DIV/DIVU/REM/REMU group.
// Operand magnitudes and sign-fix flags arrive already conditioned by the
// upstream stage; this block divides magnitudes one bit per cycle and applies
// the final sign fix to the selected quotient or remainder.
//
// Ports
//   i_clk              : clock, all state updates on the rising edge
//   i_rst              : synchronous active-high reset
//   i_div_valid        : request strobe, accepted only while o_div_ready=1
//   o_div_ready        : high in IDLE only
//   i_div_dividend     : dividend magnitude      [XLEN-1:0]
//   i_div_divisor      : divisor magnitude       [XLEN-1:0]
//   i_div_control      : 00 DIV, 01 DIVU, 10 REM, 11 REMU
//   i_div_neg_q        : negate quotient  (signed DIV only)
//   i_div_neg_r        : negate remainder (signed REM only)
//   i_div_flush        : abort anything in flight, return to IDLE
//   o_div_valid        : result available, held until i_div_result_ready
//   o_div_result       : result, forced to 0 while o_div_valid=0
//   i_div_result_ready : consumer takes the result
//
// Latency: o_div_valid rises XLEN edges after the accepting edge, or on the
// accepting edge itself when the divisor is zero.
// -----------------------------------------------------------------------------
module riscv_core_div_iter #(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_div_valid,
  output logic            o_div_ready,
  input  logic [XLEN-1:0] i_div_dividend,
  input  logic [XLEN-1:0] i_div_divisor,
  input  logic [1:0]      i_div_control,
  input  logic            i_div_neg_q,
  input  logic            i_div_neg_r,
  input  logic            i_div_flush,
  output logic            o_div_valid,
  output logic [XLEN-1:0] o_div_result,
  input  logic            i_div_result_ready
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int              CW   = (XLEN > 1) ? $clog2(XLEN) : 1;
  localparam logic [CW-1:0]   LAST = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] ONE  = XLEN'(1);

  // Select quotient or remainder and apply the sign fix. A zero divisor makes
  // DIV return all-ones regardless of the requested quotient sign.
  function automatic logic [XLEN-1:0] format_result(
    input logic [1:0]      ctrl,
    input logic            neg_q,
    input logic            neg_r,
    input logic            div_zero,
    input logic [XLEN-1:0] quot,
    input logic [XLEN-1:0] rem
  );
    logic [XLEN-1:0] res;
    case (ctrl)
      2'b00:   res = (neg_q && !div_zero) ? (~quot + ONE) : quot;
      2'b01:   res = quot;
      2'b10:   res = neg_r ? (~rem + ONE) : rem;
      default: res = rem;
    endcase
    return res;
  endfunction

  state_e          state_q,    state_d;
  logic [CW-1:0]   cnt_q,      cnt_d;
  // Shared dividend/quotient register: dividend bits shift out of the MSB
  // while quotient bits shift in at the LSB.
  logic [XLEN-1:0] dq_q,       dq_d;
  logic [XLEN-1:0] divisor_q,  divisor_d;
  logic [XLEN-1:0] rem_q,      rem_d;
  logic [1:0]      ctrl_q,     ctrl_d;
  logic            neg_q_q,    neg_q_d;
  logic            neg_r_q,    neg_r_d;
  logic            ready_q,    ready_d;
  logic            valid_q,    valid_d;
  logic [XLEN-1:0] result_q,   result_d;

  // One restoring step. The shifted partial remainder is XLEN+1 bits wide;
  // after a successful subtract it is below the divisor, so the low XLEN bits
  // of the difference are exact.
  logic [XLEN:0]   shifted;
  logic            no_borrow;
  logic [XLEN-1:0] rem_step;
  logic [XLEN-1:0] dq_step;

  always_comb begin
    shifted   = {rem_q, dq_q[XLEN-1]};
    no_borrow = (shifted >= {1'b0, divisor_q});
    rem_step  = no_borrow ? (shifted[XLEN-1:0] - divisor_q) : shifted[XLEN-1:0];
    dq_step   = {dq_q[XLEN-2:0], no_borrow};
  end

  always_comb begin
    // NOTE: every _d defaults to its _q first so no path leaves a variable
    // unassigned, which would otherwise infer a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    dq_d      = dq_q;
    divisor_d = divisor_q;
    rem_d     = rem_q;
    ctrl_d    = ctrl_q;
    neg_q_d   = neg_q_q;
    neg_r_d   = neg_r_q;
    ready_d   = ready_q;
    valid_d   = valid_q;
    result_d  = result_q;

    if (i_div_flush) begin
      // Flush beats an accept or a result handshake in the same cycle.
      state_d  = IDLE;
      cnt_d    = '0;
      ready_d  = 1'b1;
      valid_d  = 1'b0;
      result_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_div_valid) begin
            dq_d      = i_div_dividend;
            divisor_d = i_div_divisor;
            rem_d     = '0;
            ctrl_d    = i_div_control;
            neg_q_d   = i_div_neg_q;
            neg_r_d   = i_div_neg_r;
            cnt_d     = '0;
            ready_d   = 1'b0;
            if (i_div_divisor == '0) begin
              // Skip iteration: quotient is all-ones, remainder is the dividend.
              state_d  = DONE;
              valid_d  = 1'b1;
              result_d = format_result(i_div_control, i_div_neg_q, i_div_neg_r,
                                       1'b1, '1, i_div_dividend);
            end else begin
              state_d = CALC;
            end
          end
        end

        CALC: begin
          dq_d  = dq_step;
          rem_d = rem_step;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            state_d  = DONE;
            cnt_d    = '0;
            valid_d  = 1'b1;
            result_d = format_result(ctrl_q, neg_q_q, neg_r_q, 1'b0,
                                     dq_step, rem_step);
          end
        end

        DONE: begin
          if (i_div_result_ready) begin
            state_d  = IDLE;
            ready_d  = 1'b1;
            valid_d  = 1'b0;
            result_d = '0;
          end
        end

        default: begin
          state_d  = IDLE;
          cnt_d    = '0;
          ready_d  = 1'b1;
          valid_d  = 1'b0;
          result_d = '0;
        end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      dq_q      <= '0;
      divisor_q <= '0;
      rem_q     <= '0;
      ctrl_q    <= '0;
      neg_q_q   <= 1'b0;
      neg_r_q   <= 1'b0;
      ready_q   <= 1'b1;
      valid_q   <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dq_q      <= dq_d;
      divisor_q <= divisor_d;
      rem_q     <= rem_d;
      ctrl_q    <= ctrl_d;
      neg_q_q   <= neg_q_d;
      neg_r_q   <= neg_r_d;
      ready_q   <= ready_d;
      valid_q   <= valid_d;
      result_q  <= result_d;
    end
  end

  assign o_div_ready  = ready_q;
  assign o_div_valid  = valid_q;
  assign o_div_result = result_q;

endmodule

// File: tb/tb_riscv_core_div_iter.sv
// -----------------------------------------------------------------------------
// tb_riscv_core_div_iter
//
// Directed bench for riscv_core_div_iter (XLEN=32). A transaction-level model
// computes each result with native / and % and tracks only the handshake
// timing (busy countdown, result pending); a compare process checks ready,
// valid and result against it on every falling edge. Directed vectors add
// hand-computed literal results and latencies.
// -----------------------------------------------------------------------------
module tb_riscv_core_div_iter;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            i_rst;
  logic            i_div_valid;
  logic            o_div_ready;
  logic [XLEN-1:0] i_div_dividend;
  logic [XLEN-1:0] i_div_divisor;
  logic [1:0]      i_div_control;
  logic            i_div_neg_q;
  logic            i_div_neg_r;
  logic            i_div_flush;
  logic            o_div_valid;
  logic [XLEN-1:0] o_div_result;
  logic            i_div_result_ready;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  riscv_core_div_iter #(.XLEN(XLEN)) dut (
    .i_clk              (clk),
    .i_rst              (i_rst),
    .i_div_valid        (i_div_valid),
    .o_div_ready        (o_div_ready),
    .i_div_dividend     (i_div_dividend),
    .i_div_divisor      (i_div_divisor),
    .i_div_control      (i_div_control),
    .i_div_neg_q        (i_div_neg_q),
    .i_div_neg_r        (i_div_neg_r),
    .i_div_flush        (i_div_flush),
    .o_div_valid        (o_div_valid),
    .o_div_result       (o_div_result),
    .i_div_result_ready (i_div_result_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [XLEN-1:0] actual,
                       input logic [XLEN-1:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  // Architectural result of one operation, straight from the instruction rules.
  function automatic logic [XLEN-1:0] ref_result(input logic [1:0] ctrl,
      input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
      input logic nq, input logic nr);
    logic [XLEN-1:0] q, r, res;
    if (b == 0) begin
      q = '1;
      r = a;
    end else begin
      q = a / b;
      r = a % b;
    end
    case (ctrl)
      2'b00:   res = (nq && b != 0) ? (XLEN'(0) - q) : q;
      2'b01:   res = q;
      2'b10:   res = nr ? (XLEN'(0) - r) : r;
      default: res = r;
    endcase
    return res;
  endfunction

  // Transaction model: cycles remaining until the result appears, and the
  // pending result itself.
  int              m_left = 0;
  bit              m_done = 1'b0;
  logic [XLEN-1:0] m_res  = '0;

  always @(posedge clk) begin
    if (i_rst || i_div_flush) begin
      m_left = 0;
      m_done = 1'b0;
    end else if (m_done) begin
      if (i_div_result_ready) m_done = 1'b0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) m_done = 1'b1;
    end else if (i_div_valid) begin
      m_res = ref_result(i_div_control, i_div_dividend, i_div_divisor,
                         i_div_neg_q, i_div_neg_r);
      if (i_div_divisor == 0) m_done = 1'b1;
      else                    m_left = XLEN;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("ready", {31'b0, o_div_ready}, {31'b0, (!m_done && m_left == 0)});
      check("valid", {31'b0, o_div_valid}, {31'b0, m_done});
      check("result", o_div_result, m_done ? m_res : '0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_inputs();
    i_div_valid        = 1'b0;
    i_div_dividend     = '0;
    i_div_divisor      = '0;
    i_div_control      = 2'b00;
    i_div_neg_q        = 1'b0;
    i_div_neg_r        = 1'b0;
    i_div_flush        = 1'b0;
    i_div_result_ready = 1'b0;
  endtask

  // Present a request for one cycle; returns after the accepting edge.
  task automatic start_op(input logic [1:0] ctrl, input logic [XLEN-1:0] a,
                          input logic [XLEN-1:0] b, input logic nq, input logic nr);
    i_div_valid    = 1'b1;
    i_div_control  = ctrl;
    i_div_dividend = a;
    i_div_divisor  = b;
    i_div_neg_q    = nq;
    i_div_neg_r    = nr;
    tick();
    i_div_valid = 1'b0;
  endtask

  // Wait for o_div_valid, scribbling the non-flush inputs meanwhile.
  // lat counts edges after the accepting edge.
  task automatic wait_valid(output int lat);
    lat = 0;
    while (!o_div_valid && lat < 100) begin
      tick();
      lat++;
      if (!o_div_valid) begin
        i_div_valid    = 1'($urandom_range(0, 1));
        i_div_dividend = $urandom;
        i_div_divisor  = $urandom;
        i_div_control  = 2'($urandom_range(0, 3));
        i_div_neg_q    = 1'($urandom_range(0, 1));
        i_div_neg_r    = 1'($urandom_range(0, 1));
      end
    end
    clear_inputs();
  endtask

  task automatic run_op(input string name, input logic [1:0] ctrl,
                        input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                        input logic nq, input logic nr,
                        input logic [XLEN-1:0] exp_res, input int exp_lat,
                        input int hold);
    int lat;
    logic [XLEN-1:0] held;
    start_op(ctrl, a, b, nq, nr);
    wait_valid(lat);
    check({name, " latency"}, XLEN'(lat), XLEN'(exp_lat));
    check({name, " result"}, o_div_result, exp_res);
    held = o_div_result;
    for (int i = 0; i < hold; i++) begin
      tick();
      check({name, " hold valid"}, {31'b0, o_div_valid}, 32'd1);
      check({name, " hold ready"}, {31'b0, o_div_ready}, 32'd0);
      check({name, " hold result"}, o_div_result, held);
    end
    i_div_result_ready = 1'b1;
    tick();
    i_div_result_ready = 1'b0;
    check({name, " back to idle"}, {31'b0, o_div_ready}, 32'd1);
    check({name, " valid dropped"}, {31'b0, o_div_valid}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    clear_inputs();
    i_rst = 1'b1;
    i_div_valid = 1'b1;   // reset outranks a pending request
    i_div_divisor = 32'd3;
    tick();
    chk_en = 1'b1;
    tick();
    clear_inputs();
    i_rst = 1'b0;
    check("reset ready", {31'b0, o_div_ready}, 32'd1);
    check("reset valid", {31'b0, o_div_valid}, 32'd0);
    check("reset result", o_div_result, 32'd0);

    run_op("divu 100/7", 2'b01, 32'd100, 32'd7, 1'b0, 1'b0, 32'd14, 32, 0);
    run_op("remu 100/7", 2'b11, 32'd100, 32'd7, 1'b0, 1'b0, 32'd2, 32, 0);
    run_op("div -7/2",   2'b00, 32'd7, 32'd2, 1'b1, 1'b0, 32'hFFFF_FFFD, 32, 0);
    run_op("rem -7/2",   2'b10, 32'd7, 32'd2, 1'b0, 1'b1, 32'hFFFF_FFFF, 32, 0);
    run_op("div 5/0",    2'b00, 32'd5, 32'd0, 1'b1, 1'b0, 32'hFFFF_FFFF, 0, 0);
    run_op("divu 5/0",   2'b01, 32'd5, 32'd0, 1'b0, 1'b0, 32'hFFFF_FFFF, 0, 0);
    run_op("rem -5/0",   2'b10, 32'd5, 32'd0, 1'b0, 1'b1, 32'hFFFF_FFFB, 0, 0);
    run_op("remu 5/0",   2'b11, 32'd5, 32'd0, 1'b1, 1'b1, 32'd5, 0, 0);
    run_op("div ovf",    2'b00, 32'h8000_0000, 32'd1, 1'b0, 1'b0, 32'h8000_0000, 32, 0);
    run_op("rem ovf",    2'b10, 32'h8000_0000, 32'd1, 1'b0, 1'b0, 32'd0, 32, 0);
    run_op("divu flags", 2'b01, 32'hFFFF_FFFF, 32'd3, 1'b1, 1'b1, 32'h5555_5555, 32, 0);
    run_op("remu flags", 2'b11, 32'hFFFF_FFFF, 32'd10, 1'b1, 1'b1, 32'd5, 32, 0);
    run_op("divu small", 2'b01, 32'd3, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'd0, 32, 0);
    run_op("remu small", 2'b11, 32'd3, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'd3, 32, 0);
    run_op("hold 10",    2'b01, 32'd1000, 32'd10, 1'b0, 1'b0, 32'd100, 32, 10);

    // Flush with the iteration counter at 15, then accept straight away.
    start_op(2'b01, 32'd50, 32'd5, 1'b0, 1'b0);
    for (int i = 0; i < 15; i++) tick();
    i_div_flush = 1'b1;
    tick();
    i_div_flush = 1'b0;
    check("flush calc ready", {31'b0, o_div_ready}, 32'd1);
    check("flush calc valid", {31'b0, o_div_valid}, 32'd0);
    run_op("after flush", 2'b01, 32'd50, 32'd5, 1'b0, 1'b0, 32'd10, 32, 0);

    // Reset with the counter at 20 and a request on the inputs.
    start_op(2'b00, 32'd77, 32'd7, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) tick();
    i_rst = 1'b1;
    i_div_valid = 1'b1;
    tick();
    i_rst = 1'b0;
    i_div_valid = 1'b0;
    check("rst calc ready", {31'b0, o_div_ready}, 32'd1);
    check("rst calc valid", {31'b0, o_div_valid}, 32'd0);
    run_op("after rst", 2'b00, 32'd77, 32'd7, 1'b1, 1'b0, 32'hFFFF_FFF5, 32, 0);

    // Flush alongside a request in IDLE: nothing is accepted.
    i_div_flush = 1'b1;
    i_div_valid = 1'b1;
    i_div_divisor = 32'd0;
    tick();
    clear_inputs();
    check("flush idle ready", {31'b0, o_div_ready}, 32'd1);
    check("flush idle valid", {31'b0, o_div_valid}, 32'd0);

    // Flush in DONE together with the result handshake discards the result.
    start_op(2'b10, 32'd9, 32'd0, 1'b0, 1'b0);
    wait_valid(lat);
    check("done flush pre result", o_div_result, 32'd9);
    i_div_flush = 1'b1;
    i_div_result_ready = 1'b1;
    tick();
    clear_inputs();
    check("done flush ready", {31'b0, o_div_ready}, 32'd1);
    check("done flush valid", {31'b0, o_div_valid}, 32'd0);
    check("done flush result", o_div_result, 32'd0);
    tick();
    tick();

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
